// File: rtl/vo_pkg.sv
// Shared types and constants for the video-out pixel feeder.
package vo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN
    } state_e;

    localparam int R_W    = 5;
    localparam int G_W    = 6;
    localparam int B_W    = 5;
    localparam int PIX_W  = R_W + G_W + B_W;
    localparam int WORD_W = 2 * PIX_W;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 720;

endpackage

// File: rtl/vo_sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on rdata one cycle after it is pushed.
module vo_sync_fifo
    import vo_pkg::*;
#(
    parameter int WIDTH      = WORD_W,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      ram_q;
    logic [WIDTH-1:0]      byp_data_q;
    logic                  byp_q, byp_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign level = level_q;
    assign rdata = byp_q ? byp_data_q : ram_q;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        // The RAM read lags one cycle, so a word written to the next head slot is forwarded.
        byp_d = do_push && (wr_ptr_q == rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
        ram_q      <= mem[rd_ptr_d];
        byp_data_q <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            byp_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            byp_q    <= byp_d;
        end
    end

endmodule

// File: rtl/vo_pixel_feeder.sv
// Feeds RGB565 pixels from a buffered DMA word stream to the video output stage,
// resynchronising on each vsync leading edge.
module vo_pixel_feeder
    import vo_pkg::*;
#(
    parameter int   DEPTH_LOG2 = 9,
    parameter int   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int   V_ACTIVE   = V_ACTIVE_DEF,
    parameter logic VS_POL     = 1'b1
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  vout_vs,
    input  logic                  vout_de,
    output logic [PIX_W-1:0]      video_data,
    output logic                  video_de,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W = $clog2(TOTAL + 1);

    state_e             state_q, state_d;
    logic               vs_q;
    logic               half_q, half_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               underflow_q, underflow_d;
    logic [PIX_W-1:0]   video_data_q, video_data_d;
    logic               video_de_q;
    logic               frame_start_q, frame_start_d;
    logic               frame_done_q, frame_done_d;

    logic               vs_edge;
    logic               flush;
    logic               fifo_push, fifo_pop;
    logic [WORD_W-1:0]  fifo_rdata;
    logic               fifo_empty, fifo_full;

    assign flush     = (state_q == ST_FLUSH);
    assign in_ready  = (state_q == ST_RUN) && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    vo_sync_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (video_clk),
        .rst   (rst),
        .clr   (flush),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    always_comb begin
        vs_edge       = (vout_vs == VS_POL) && (vs_q != VS_POL);
        state_d       = state_q;
        if (state_q == ST_FLUSH) state_d = ST_RUN;
        if (vs_edge)             state_d = ST_FLUSH;
        frame_start_d = vs_edge;

        fifo_pop      = 1'b0;
        video_data_d  = '0;
        half_d        = half_q;
        cnt_d         = cnt_q;
        underflow_d   = underflow_q;
        frame_done_d  = 1'b0;
        // Requests past the end of the frame, or outside RUN, are answered with black.
        if (vout_de && (state_q == ST_RUN) && (cnt_q < CNT_W'(TOTAL))) begin
            cnt_d        = cnt_q + 1'b1;
            frame_done_d = (cnt_q == CNT_W'(TOTAL - 1));
            if (fifo_empty) begin
                underflow_d = 1'b1;
            end else begin
                video_data_d = half_q ? fifo_rdata[WORD_W-1:PIX_W] : fifo_rdata[PIX_W-1:0];
                half_d       = !half_q;
                fifo_pop     = half_q;
            end
        end
        if (flush) begin
            half_d      = 1'b0;
            cnt_d       = '0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge video_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            vs_q          <= ~VS_POL;
            half_q        <= 1'b0;
            cnt_q         <= '0;
            underflow_q   <= 1'b0;
            video_data_q  <= '0;
            video_de_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vout_vs;
            half_q        <= half_d;
            cnt_q         <= cnt_d;
            underflow_q   <= underflow_d;
            video_data_q  <= video_data_d;
            video_de_q    <= vout_de;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign video_data  = video_data_q;
    assign video_de    = video_de_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign underflow   = underflow_q;

endmodule
